// File: rtl/arilla_bus_arbiter.sv
// arilla_bus_arbiter: round-robin bus arbiter with transaction hold, beat cap and intercept priority.
// Optional macro ARB_TURNAROUND_EN inserts one idle (gnt=0) cycle between tenures.
module arilla_bus_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_BEATS       = 16,
    parameter int PRIORITY_MASTER = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         i_req,
    input  logic [NUM_MASTERS-1:0]         i_last,
    input  logic                           i_available,
    input  logic                           i_intercept,
    output logic [NUM_MASTERS-1:0]         o_gnt,
    output logic                           o_gnt_valid,
    output logic [$clog2(NUM_MASTERS)-1:0] o_gnt_id,
    output logic [7:0]                     o_beat_cnt
);
    localparam int N  = NUM_MASTERS;
    localparam int IW = $clog2(NUM_MASTERS);

`ifdef ARB_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWNED} state_t;
`endif

    state_t        r_state, w_state;
    logic [N-1:0]  r_gnt, w_gnt, w_cand;
    logic [IW-1:0] r_id, w_id, r_ptr, w_ptr, w_inc, w_pp;
    logic [7:0]    r_beat;
    logic [IW:0]   w_pick;
    logic          w_owned, w_own_req, w_beat, w_done, w_abandon, w_preempt, w_release, w_load;

    // Returns {found, index}: intercept winner first, else first candidate at or above p (wrapping).
    function automatic logic [IW:0] arb(input logic [N-1:0] c, input logic [IW-1:0] p, input logic ic);
        logic [2*N-1:0] d;
        logic [IW:0]    s;
        arb = '0;
        d = {c, c} >> p;
        for (int k = N - 1; k >= 0; k--) begin
            s = {1'b0, p} + (IW+1)'(k);
            if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
            if (|(d & ((2*N)'(1) << k))) arb = {1'b1, s[IW-1:0]};
        end
        if (ic && c[PRIORITY_MASTER]) arb = {1'b1, IW'(PRIORITY_MASTER)};
    endfunction

    assign w_owned   = r_state == OWNED;
    assign w_own_req = i_req[r_id];
    assign w_beat    = w_owned && w_own_req && i_available;
    assign w_done    = w_beat && i_last[r_id];
    assign w_abandon = w_owned && !w_own_req;
    assign w_preempt = (MAX_BEATS != 0) && w_beat && ({1'b0, r_beat} + 9'd1 == 9'(MAX_BEATS))
                       && |(i_req & ~r_gnt) && !(i_intercept && r_id == IW'(PRIORITY_MASTER));
    assign w_release = w_done || w_abandon || w_preempt;
    assign w_inc     = (r_id == IW'(N - 1)) ? '0 : r_id + IW'(1);
    // The releasing owner sits out the handover decision; it is re-granted only if nobody else wants the bus.
    assign w_cand    = w_owned ? i_req & ~r_gnt : i_req;
    assign w_pp      = w_owned ? w_inc : r_ptr;
    assign w_pick    = arb(w_cand, w_pp, i_intercept);

    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_id    = r_id;
        w_ptr   = r_ptr;
        w_load  = 1'b0;
        if (w_owned) begin
            if (w_release) begin
                w_ptr = w_inc;
`ifdef ARB_TURNAROUND_EN
                w_state = TURN;
                w_gnt   = '0;
                w_id    = '0;
`else
                if (w_pick[IW]) begin
                    w_load          = 1'b1;
                    w_id            = w_pick[IW-1:0];
                    w_gnt           = '0;
                    w_gnt[w_id]     = 1'b1;
                end else if (w_own_req) begin
                    w_load = 1'b1;
                end else begin
                    w_state = IDLE;
                    w_gnt   = '0;
                    w_id    = '0;
                end
`endif
            end
        end else if (w_pick[IW]) begin
            w_state     = OWNED;
            w_load      = 1'b1;
            w_id        = w_pick[IW-1:0];
            w_gnt       = '0;
            w_gnt[w_id] = 1'b1;
        end else begin
            w_state = IDLE;
            w_gnt   = '0;
            w_id    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_id    <= w_id;
            r_ptr   <= w_ptr;
            r_beat  <= w_load ? 8'd0 : (w_beat && r_beat != 8'hFF) ? r_beat + 8'd1 : r_beat;
        end
    end

    assert property (@(posedge clk) $onehot0(r_gnt)) else $error("gnt not one-hot: %b", r_gnt);

    assign o_gnt       = r_gnt;
    assign o_gnt_valid = |r_gnt;
    assign o_gnt_id    = r_id;
    assign o_beat_cnt  = r_beat;
endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// tb_arilla_bus_arbiter: directed vector table plus hand sequences for arilla_bus_arbiter (2 masters, cap 4).
module tb_arilla_bus_arbiter;
    typedef struct packed {
        logic       rst;
        logic [1:0] req;
        logic [1:0] last;
        logic       av;
        logic       ic;
        logic [1:0] gnt;
        logic [7:0] beat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] last = '0;
    logic       available = 1'b0;
    logic       intercept = 1'b0;
    logic [1:0] gnt;
    logic       gnt_valid;
    logic       gnt_id;
    logic [7:0] beat_cnt;
    vec_t       v[$];
    int         n_chk = 0;
    int         n_fail = 0;

    arilla_bus_arbiter #(.NUM_MASTERS(2), .MAX_BEATS(4), .PRIORITY_MASTER(1)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_last(last), .i_available(available),
        .i_intercept(intercept), .o_gnt(gnt), .o_gnt_valid(gnt_valid), .o_gnt_id(gnt_id),
        .o_beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] q, input logic [1:0] l, input logic a,
                       input logic c, input logic [1:0] g, input logic [7:0] b);
        v.push_back('{rst: r, req: q, last: l, av: a, ic: c, gnt: g, beat: b});
    endtask

    task automatic step(input logic r, input logic [1:0] q, input logic [1:0] l, input logic a, input logic c);
        rst = r; req = q; last = l; available = a; intercept = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [1:0] g, input logic [7:0] b);
        chk("gnt", idx, 32'(gnt), 32'(g));
        chk("gnt_valid", idx, 32'(gnt_valid), 32'(|g));
        chk("gnt_id", idx, 32'(gnt_id), 32'(g == 2'b10));
        chk("beat_cnt", idx, 32'(beat_cnt), 32'(b));
    endtask

    initial begin
        // reset, then single master: 1-cycle latency, 3 beats, re-grant on last, drop -> idle
        add(1, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        add(0, 2'b01, 2'b00, 0, 0, 2'b01, 0);
        add(0, 2'b01, 2'b00, 1, 0, 2'b01, 1);
        add(0, 2'b01, 2'b00, 1, 0, 2'b01, 2);
        add(0, 2'b01, 2'b01, 1, 0, 2'b01, 0);
        add(0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        // both requesting, 2-beat transactions alternate with no gap (pointer now 1)
        add(0, 2'b11, 2'b00, 0, 0, 2'b10, 0);
        add(0, 2'b11, 2'b00, 1, 0, 2'b10, 1);
        add(0, 2'b11, 2'b10, 1, 0, 2'b01, 0);
        add(0, 2'b11, 2'b00, 1, 0, 2'b01, 1);
        add(0, 2'b11, 2'b01, 1, 0, 2'b10, 0);
        add(0, 2'b11, 2'b00, 1, 0, 2'b10, 1);
        add(0, 2'b11, 2'b10, 1, 0, 2'b01, 0);
        // master0 long transaction preempted on the 4th beat
        for (int k = 1; k <= 3; k++) add(0, 2'b11, 2'b00, 1, 0, 2'b01, 8'(k));
        add(0, 2'b11, 2'b00, 1, 0, 2'b10, 0);
        // master1 abandons; master0 alone keeps the grant past the cap
        add(0, 2'b01, 2'b00, 0, 0, 2'b01, 0);
        for (int k = 1; k <= 5; k++) add(0, 2'b01, 2'b00, 1, 0, 2'b01, 8'(k));
        // bus stalled 5 cycles, then intercept rises mid-tenure: no revoke, no count
        for (int k = 0; k < 5; k++) add(0, 2'b01, 2'b00, 0, 0, 2'b01, 5);
        add(0, 2'b11, 2'b00, 0, 1, 2'b01, 5);
        add(0, 2'b00, 2'b00, 0, 0, 2'b00, 5);
        // intercept from idle with pointer 0 favours master1, which runs 6 beats unpreempted
        add(1, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        add(0, 2'b11, 2'b00, 0, 1, 2'b10, 0);
        for (int k = 1; k <= 6; k++) add(0, 2'b11, 2'b00, 1, 1, 2'b10, 8'(k));
        add(0, 2'b11, 2'b10, 1, 1, 2'b01, 0);
        add(0, 2'b11, 2'b01, 1, 0, 2'b10, 0);
        add(0, 2'b11, 2'b00, 1, 0, 2'b10, 1);
        // reset mid-tenure with pointer at 1; afterwards master0 wins from pointer 0
        add(1, 2'b11, 2'b00, 1, 0, 2'b00, 0);
        add(0, 2'b11, 2'b00, 0, 0, 2'b01, 0);

        for (int i = 0; i < v.size(); i++) begin
            step(v[i].rst, v[i].req, v[i].last, v[i].av, v[i].ic);
            chk_all(i, v[i].gnt, v[i].beat);
        end

        // beat counter saturates at 255
        repeat (260) step(0, 2'b01, 2'b00, 1, 0);
        chk_all(1000, 2'b01, 8'd255);

        // owner drops req: bus released within a bounded number of cycles
        begin
            int t = 0;
            step(0, 2'b00, 2'b00, 0, 0);
            while (gnt_valid && t < 4) begin
                step(0, 2'b00, 2'b00, 0, 0);
                t++;
            end
            chk("release_cycles", 1001, 32'(t), 32'd0);
            chk("release_valid", 1001, 32'(gnt_valid), 32'd0);
        end

        // new request arriving in the same cycle as the owner's last beat wins the handover
        step(0, 2'b01, 2'b00, 0, 0);
        chk_all(1002, 2'b01, 8'd0);
        step(0, 2'b11, 2'b01, 1, 0);
        chk_all(1003, 2'b10, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
